// File: rtl/uart_rx.sv
// UART receiver: synchronised RX pin, mid-bit sampling FSM, FWFT receive FIFO, sticky status.
// Optional even-parity frame (8E1) when UART_RX_PARITY_EN is defined; default build is 8N1.
module uart_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            i_Clk,
  input  logic                            i_Reset,
  input  logic [15:0]                     i_ClksPerBit,
  input  logic                            i_UART_RX,
  input  logic                            i_RdEn,
  input  logic                            i_ClrErr,
  output logic [7:0]                      o_RxData,
  output logic                            o_Empty,
  output logic                            o_Full,
  output logic [$clog2(FIFO_DEPTH):0]     o_Count,
  output logic                            o_FrameErr,
  output logic                            o_Overrun,
  output logic                            o_ParityErr,
  output logic                            o_Busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] n_reg, n_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [15:0] n_eff;
  logic        push;
  logic        frame_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          empty, full, pop, wr_en, overrun_set;
  logic          frame_err_reg, overrun_reg;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) sync_reg <= '1;
    else         sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_UART_RX};
  end
  assign rx = sync_reg[SYNC_STAGES-1];

  // Very short bit periods would put the mid-bit sample on the edge, so clamp to 4.
  assign n_eff = (i_ClksPerBit < 16'd4) ? 16'd4 : i_ClksPerBit;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      n_reg     <= 16'd4;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      n_reg     <= n_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_set;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    n_next     = n_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    push       = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (!rx) begin
          // Counters load "period minus one" so a sample lands exactly N cycles later.
          n_next     = n_eff;
          cnt_next   = (n_eff >> 1) - 16'd1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (cnt_reg == '0) begin
          if (!rx) begin
            cnt_next   = n_reg - 16'd1;
            idx_next   = '0;
            state_next = S_DATA;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_reg == '0) begin
          shift_next[idx_reg] = rx;
          cnt_next            = n_reg - 16'd1;
          if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_reg == '0) begin
          parity_set = (rx != (^shift_reg));
          cnt_next   = n_reg - 16'd1;
          state_next = S_STOP;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_reg == '0) begin
          if (rx) begin
            push       = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_set  = 1'b1;
            state_next = S_BREAK;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      S_BREAK: begin
        if (rx) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == DEPTH_C);
  assign pop         = i_RdEn && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign wr_en       = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  always_ff @(posedge i_Clk) begin
    if (wr_en) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (frame_set)     frame_err_reg <= 1'b1;
      else if (i_ClrErr) frame_err_reg <= 1'b0;
      if (overrun_set)   overrun_reg   <= 1'b1;
      else if (i_ClrErr) overrun_reg   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_reg;
  always_ff @(posedge i_Clk) begin
    if (i_Reset)         parity_err_reg <= 1'b0;
    else if (parity_set) parity_err_reg <= 1'b1;
    else if (i_ClrErr)   parity_err_reg <= 1'b0;
  end
  assign o_ParityErr = parity_err_reg;
`else
  assign o_ParityErr = 1'b0;
`endif

  assign o_RxData   = empty ? 8'h00 : mem[rd_ptr_reg];
  assign o_Empty    = empty;
  assign o_Full     = full;
  assign o_Count    = count_reg;
  assign o_FrameErr = frame_err_reg;
  assign o_Overrun  = overrun_reg;
  assign o_Busy     = (state_reg != S_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive engine: the receive-side counterpart to the SOC UART transmitter.
- Shares the transmitter's 16-bit clocks-per-bit setting and frame format: 8N1, LSB first. With the optional parity feature the format is 8E1.
- Synchronises the asynchronous RX pin, detects and validates start bits, samples each bit at mid-bit, checks the stop bit, and buffers received bytes in a small FIFO.
- The future Avalon register wrapper reads bytes and sticky status from this block.

Parameters:
- FIFO_DEPTH, 4: number of entries in the receive FIFO; must be a power of 2, range 2..16.
- SYNC_STAGES, 2: number of synchroniser flops on i_UART_RX; minimum 2.

Ports:
- i_Clk  input  1  system clock
- i_Reset  input  1  synchronous reset, active-high
- i_ClksPerBit  input  16  clock cycles per bit, same encoding as the transmitter
- i_UART_RX  input  1  asynchronous serial input; idle level is high
- i_RdEn  input  1  pops the FIFO head when the FIFO is non-empty
- i_ClrErr  input  1  clears all sticky error flags
- o_RxData  output  8  FIFO head, first-word fall-through; 0 when empty
- o_Empty  output  1  FIFO empty
- o_Full  output  1  FIFO full
- o_Count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_FrameErr  output  1  sticky: stop bit sampled low
- o_Overrun  output  1  sticky: byte dropped because the FIFO was full
- o_ParityErr  output  1  sticky parity error; tied 0 when the optional feature is out
- o_Busy  output  1  FSM is not in IDLE

Behaviour:
- Reset values:
  - Synchroniser flops = 1.
  - FSM = IDLE.
  - FIFO pointers = 0 and count = 0, so o_Empty = 1, o_Full = 0, o_RxData = 0.
  - All error flags = 0; o_Busy = 0.
- Reset asserted mid-frame discards the partial byte and the FIFO contents.
- Effective bit period: N = max(i_ClksPerBit, 4). N is latched at start-bit detection; changes during a frame take effect on the next frame.
- "rx" below means the output of the final synchroniser stage.
- FSM states:
  - IDLE: when rx = 0, load counter with N>>1 and go to START.
  - START: count down. At 0, sample rx.
    - rx = 0: load N, clear bit index, go to DATA.
    - rx = 1: false start, return to IDLE; nothing is flagged.
  - DATA: count down. At 0, shift rx into bit[index] (LSB first) and reload N. After index 7 go to PARITY if the feature is enabled, otherwise STOP.
  - PARITY (feature only): at 0, sample the parity bit and reload N; go to STOP.
  - STOP: at 0, sample rx.
    - rx = 1: push the byte and go to IDLE in the same cycle. No wait for the end of the stop bit, so a following start bit is caught.
    - rx = 0: set o_FrameErr, discard the byte, go to BREAK.
  - BREAK: stay until rx = 1, then go to IDLE. A held-low line therefore yields exactly one frame error, not repeated frames.
- Sampling points, measured from the first cycle rx = 0 is seen:
  - start-bit check: N>>1 cycles
  - data bit k: (N>>1) + (k+1)·N cycles
  - stop bit: (N>>1) + 9·N cycles, or + 10·N with parity
- Push timing: the push happens on the stop-sample edge. o_Empty falls and o_RxData is valid on the following cycle.
- FIFO pop: i_RdEn with o_Empty = 0 advances the read pointer; o_RxData shows the next entry the next cycle. i_RdEn when empty is ignored.
- FIFO push when full:
  - Without a same-cycle pop: the byte is dropped, o_Overrun is set, and the FIFO is unchanged.
  - With a same-cycle pop: both happen, the count stays the same, and no overrun is flagged.
- Push and pop in the same cycle when non-full: both happen and the count is unchanged.
- Sticky flags:
  - i_ClrErr clears all flags.
  - If a set event coincides with i_ClrErr, the set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame includes an even-parity bit after data bit 7.
  - Parity mismatch sets o_ParityErr.
  - The byte is still pushed if the stop bit is good; the error is flagged, not filtered.
- Undefined:
  - There is no PARITY state and the frame is 8N1.
  - o_ParityErr is constant 0.

Test Plan:
- N=16, send 0xA5 in 8N1:
  - o_Empty falls 1 cycle after the stop sample, which is 152 cycles after rx is seen low.
  - o_RxData = 0xA5; pulsing i_RdEn gives o_Empty = 1.
- N=16, RX low for 5 cycles then high: no push, no flags, FSM back in IDLE; a following 0x3C is received correctly.
- N=16, send 0x55 with the stop bit low, then hold low for 40 cycles:
  - o_FrameErr = 1, FIFO empty, exactly one error.
  - After rx goes high, 0x12 is received; i_ClrErr clears o_FrameErr.
- FIFO_DEPTH=4, send 0x01..0x05 without reads:
  - o_Full = 1, o_Overrun = 1.
  - Reads return 0x01..0x04, then o_Empty = 1.
- i_Reset asserted mid-byte after data bit 3, then deasserted; send 0x7E: only 0x7E is in the FIFO and all flags are 0.
- UART_RX_PARITY_EN, N=8:
  - Send 0x07 with parity bit 1: received, no error.
  - Send 0x07 with parity bit 0: o_ParityErr = 1 and the byte 0x07 is still pushed.
